// File: rtl/alu_share_arbiter.sv
// Two-requester valid/ready arbiter around one shared ALU with a single-entry tagged response slot.
// Optional round-robin tie-breaking is enabled by defining ALU_ARB_RR_EN; fixed req0 priority otherwise.
module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t state, state_nxt;
  logic        can_accept;
  logic        grant;
  logic        accept;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [32:0] alu_res;

  // Result is {err, data}; illegal codes yield zero data so no undefined value escapes.
  // LUI expects the immediate already placed in op2[31:12].
  function automatic logic [32:0] alu_f(input logic [3:0] ctrl, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] r;
    r = {1'b0, 32'h0000_0000};
    case (ctrl)
      ALU_SLL:  r = {1'b0, a << b[4:0]};
      ALU_SRL:  r = {1'b0, a >> b[4:0]};
      ALU_SRA:  r = {1'b0, $signed(a) >>> b[4:0]};
      ALU_ADD:  r = {1'b0, a + b};
      ALU_SUB:  r = {1'b0, a - b};
      ALU_XOR:  r = {1'b0, a ^ b};
      ALU_OR:   r = {1'b0, a | b};
      ALU_AND:  r = {1'b0, a & b};
      ALU_SLT:  r = {1'b0, 31'h0000_0000, $signed(a) < $signed(b)};
      ALU_SLTU: r = {1'b0, 31'h0000_0000, a < b};
      ALU_LUI:  r = {1'b0, b};
      default:  r = {1'b1, 32'h0000_0000};
    endcase
    return r;
  endfunction

`ifdef ALU_ARB_RR_EN
  logic rr_last;
`endif

  always_comb begin
    can_accept = !rsp_valid || rsp_ready;
    grant      = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant = !rr_last;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
    req0_ready = can_accept && !grant;
    req1_ready = can_accept && grant;
    accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    alu_ctrl   = grant ? req1_ctrl : req0_ctrl;
    alu_op1    = grant ? req1_op1  : req0_op1;
    alu_op2    = grant ? req1_op2  : req0_op2;
    alu_res    = alu_f(alu_ctrl, alu_op1, alu_op2);
  end

  // Slot next state: a refill wins over a drain on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = FULL;
        else        state_nxt = EMPTY;
      end
      FULL: begin
        if (accept)         state_nxt = FULL;
        else if (rsp_ready) state_nxt = EMPTY;
        else                state_nxt = FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_data <= 32'h0000_0000;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= {CNT_W{1'b0}};
`ifdef ALU_ARB_RR_EN
      rr_last  <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_data <= alu_res[31:0];
        rsp_err  <= alu_res[32];
        rsp_id   <= grant;
        if (op_count != CNT_MAX) op_count <= op_count + CNT_ONE;
`ifdef ALU_ARB_RR_EN
        rr_last  <= grant;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Table-driven bench with a response scoreboard for alu_share_arbiter; a CNT_W=4 twin
// shares the stimulus to exercise counter saturation. Honours ALU_ARB_RR_EN.
module tb_alu_share_arbiter;

  localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, SRA = 4'd2, ADD = 4'd3, SUB = 4'd4,
                         XOR = 4'd5, ORR = 4'd6, ANDD = 4'd7, SLT = 4'd8, SLTU = 4'd9,
                         LUI = 4'd10, BAD = 4'd15;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic v0; logic [3:0] c0; logic [31:0] a0; logic [31:0] b0; logic [31:0] x0; logic e0;
    logic v1; logic [3:0] c1; logic [31:0] a1; logic [31:0] b1; logic [31:0] x1; logic e1;
    logic rr;
  } vec_t;

  typedef struct { logic [31:0] data; logic id; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req0_op1 = 32'h0, req0_op2 = 32'h0, req1_op1 = 32'h0, req1_op2 = 32'h0;
  logic [3:0] req0_ctrl = 4'h0, req1_ctrl = 4'h0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] op_count;
  logic r0_4, r1_4, v_4, id_4, err_4;
  logic [31:0] data_4;
  logic [3:0] op_count4;

  always #5 clk = ~clk;

  alu_share_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_share_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_4), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(r1_4), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .rsp_valid(v_4), .rsp_ready(rsp_ready), .rsp_data(data_4),
    .rsp_id(id_4), .rsp_err(err_4), .op_count(op_count4)
  );

  int checks = 0;
  int passed = 0;
  vec_t tbl[19];
  vec_t cur;
  rsp_t q[$];
  logic m_valid = 1'b0;
  logic m_rr = 1'b1;
  int m_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic v0, input logic [3:0] c0, input logic [31:0] a0,
                              input logic [31:0] b0, input logic [31:0] x0, input logic e0,
                              input logic v1, input logic [3:0] c1, input logic [31:0] a1,
                              input logic [31:0] b1, input logic [31:0] x1, input logic e1,
                              input logic rr);
    vec_t v;
    v.v0 = v0; v.c0 = c0; v.a0 = a0; v.b0 = b0; v.x0 = x0; v.e0 = e0;
    v.v1 = v1; v.c1 = c1; v.a1 = a1; v.b1 = b1; v.x1 = x1; v.e1 = e1;
    v.rr = rr;
    return v;
  endfunction

  function automatic vec_t idle(input logic rr);
    return mk(1'b0, ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, ADD, 32'h0, 32'h0, 32'h0, 1'b0, rr);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rr = 1'b1; m_count = 0;
    q.delete();
  endtask

  // Drive cur, check outputs against the model mid-cycle, advance model and clock by one cycle.
  task automatic step();
    logic can, g, acc;
    rsp_t r;
    req0_valid = cur.v0; req0_ctrl = cur.c0; req0_op1 = cur.a0; req0_op2 = cur.b0;
    req1_valid = cur.v1; req1_ctrl = cur.c1; req1_op1 = cur.a1; req1_op2 = cur.b1;
    rsp_ready = cur.rr;
    #1;
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
    chk("rsp_valid_w4", {31'h0, v_4}, {31'h0, m_valid});
    if (m_valid && q.size() > 0) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_id", {31'h0, rsp_id}, {31'h0, q[0].id});
      chk("rsp_err", {31'h0, rsp_err}, {31'h0, q[0].err});
    end
    chk("op_count", {16'h0, op_count}, m_count);
    chk("op_count_w4", {28'h0, op_count4}, (m_count > 15) ? 15 : m_count);
    can = !m_valid || cur.rr;
    if (cur.v0 && cur.v1) g = RR ? !m_rr : 1'b0;
    else g = cur.v1;
    chk("req0_ready", {31'h0, req0_ready}, {31'h0, can && !g});
    chk("req1_ready", {31'h0, req1_ready}, {31'h0, can && g});
    acc = can && (g ? cur.v1 : cur.v0);
    if (m_valid && cur.rr && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      r.data = g ? cur.x1 : cur.x0;
      r.err  = g ? cur.e1 : cur.e0;
      r.id   = g;
      q.push_back(r);
      m_count++;
      m_rr = g;
    end
    m_valid = acc ? 1'b1 : (cur.rr ? 1'b0 : m_valid);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_reset_state();
    #1;
    chk("reset_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_data", rsp_data, 32'h0);
    chk("reset_id", {31'h0, rsp_id}, 32'h0);
    chk("reset_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_count", {16'h0, op_count}, 32'h0);
    chk("reset_count_w4", {28'h0, op_count4}, 32'h0);
  endtask

  initial begin
    tbl[0]  = mk(1, ADD, 32'd5, 32'd7, 32'd12, 0,  0, ADD, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, ADD, 0, 0, 0, 0,  1, SUB, 32'd10, 32'd3, 32'd7, 0, 1);
    tbl[2]  = mk(1, ANDD, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0,  0, ADD, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, ADD, 0, 0, 0, 0,  1, ORR, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 0, 1);
    tbl[4]  = mk(1, XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0,  0, ADD, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, ADD, 0, 0, 0, 0,  1, SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
    tbl[6]  = mk(1, SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0,  0, ADD, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, SLL, 32'd1, 32'd31, 32'h8000_0000, 0,  0, ADD, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, ADD, 0, 0, 0, 0,  1, SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1);
    tbl[9]  = mk(1, LUI, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 0,  0, ADD, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, ADD, 0, 0, 0, 0,  1, BAD, 32'd1, 32'd1, 32'd0, 1, 1);
    tbl[11] = idle(1'b1);
    for (int i = 12; i < 18; i++)
      tbl[i] = mk(1, SUB, 32'd10, 32'd3, 32'd7, 0,  1, SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1);
    tbl[18] = idle(1'b1);

    cur = idle(1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_reset_state();
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      cur = tbl[i];
      step();
    end

    // Stall: slot held for three cycles while req1 waits, then drain and refill on one edge.
    cur = mk(1, ADD, 32'd100, 32'd23, 32'd123, 0,  0, ADD, 0, 0, 0, 0, 1);
    step();
    cur = mk(0, ADD, 0, 0, 0, 0,  1, SUB, 32'd50, 32'd8, 32'd42, 0, 0);
    repeat (3) step();
    cur.rr = 1'b1;
    step();
    cur = idle(1'b1);
    repeat (2) step();

    // Reset with a response pending, then the first tie must go to req0.
    cur = mk(1, ADD, 32'd1, 32'd2, 32'd3, 0,  0, ADD, 0, 0, 0, 0, 0);
    step();
    cur = idle(1'b0);
    step();
    do_reset();
    chk_reset_state();
    @(negedge clk);
    cur = mk(1, XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0,
             1, ADD, 32'd2, 32'd2, 32'd4, 0, 1);
    step();
    cur = idle(1'b1);
    step();

    // Saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cur = mk(1, ADD, i, 32'd1, i + 1, 0,  0, ADD, 0, 0, 0, 0, 1);
      step();
    end
    cur = idle(1'b1);
    step();
    #1;
    chk("final_count", {16'h0, op_count}, 32'd20);
    chk("final_count_w4", {28'h0, op_count4}, 32'd15);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
